seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 226 ++++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//
// Time-multiplexed driver for a row of common-anode seven-segment digits.
// A slot counter (cnt) walks each digit (idx) through CLK_DIV clock cycles.
// The first GUARD cycles of every slot keep all anodes dark to hide ghosting.
// New display data arrives on a single-cycle load strobe. It is parked in a
// pending register and is only copied into the display register at the last
// cycle of a frame, so the digits of one frame never come from two loads.
//
// Optional feature: define SEG7_LEADING_ZERO_SUPPRESS_EN to darken leading
// zero digits. Digit 0 is never darkened, and a digit that requests its
// decimal point is never darkened.
//
// All outputs are registered. They show the state of the previous cycle.

module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS = 4,      // 1..8
  parameter int unsigned CLK_DIV    = 50000,  // cycles per digit slot, >= 2
  parameter int unsigned GUARD      = 16      // dark cycles at slot start
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  output logic [6:0]              segs,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Active-low segment pattern for a dark digit.
  localparam logic [6:0] SEGS_OFF = 7'h7F;

  // Map a hex nibble to an active-low gfedcba pattern.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  logic [4*NUM_DIGITS-1:0] disp_value_q, disp_value_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d;

  logic [4*NUM_DIGITS-1:0] pend_value_q, pend_value_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                    pend_valid_q, pend_valid_d;

  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              segs_q, segs_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q;

  logic                    cnt_last;
  logic                    idx_last;
  logic                    wrap;
  logic                    guard_done;
  logic [NUM_DIGITS-1:0]   blank_eff;

  assign cnt_last   = (cnt_q == CNT_LAST);
  assign idx_last   = (idx_q == IDX_LAST);
  // With a single digit every slot end is also a frame end.
  assign wrap       = cnt_last && idx_last;
  assign guard_done = (cnt_q >= CNT_GUARD);

  // ---------------------------------------------------------------------------
  // State register: counters, display/pending data, registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: every register here, including the display and pending data, is
  // reset explicitly: the display must come up showing zeros, and a load
  // that was pending when reset arrived must be discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_value_q <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      pend_value_q <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_valid_q <= 1'b0;
      an_q         <= '1;
      segs_q       <= SEGS_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the values
      // from before this edge regardless of statement order.
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_value_q <= disp_value_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      pend_value_q <= pend_value_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      segs_q       <= segs_d;
      dp_q         <= dp_d;
      frame_done_q <= wrap;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: scan counters, pending capture, frame-boundary display update
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: each variable gets its hold value first, so no path through
    // this block leaves one unassigned (no latch inferred).
    cnt_d        = cnt_last ? '0 : cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    disp_value_d = disp_value_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_valid_d = pend_valid_q;

    if (cnt_last) begin
      idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
    end

    if (wrap) begin
      // A load on the wrap cycle itself goes straight to the display and
      // takes priority over anything parked earlier in the frame.
      if (load) begin
        disp_value_d = value;
        disp_dp_d    = dp_in;
        disp_blank_d = blank;
      end else if (pend_valid_q) begin
        disp_value_d = pend_value_q;
        disp_dp_d    = pend_dp_q;
        disp_blank_d = pend_blank_q;
      end
      pend_valid_d = 1'b0;
    end else if (load) begin
      // The latest load within a frame wins.
      pend_value_d = value;
      pend_dp_d    = dp_in;
      pend_blank_d = blank;
      pend_valid_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Effective blanking: explicit blank plus optional leading-zero suppression
  // ---------------------------------------------------------------------------
`ifdef SEG7_LEADING_ZERO_SUPPRESS_EN
  always_comb begin
    logic higher_zero;
    blank_eff   = disp_blank_q;
    higher_zero = 1'b1;
    // Walk from the most significant digit down. Stop darkening digits at
    // the first non-zero nibble. Digit 0 is never considered.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      higher_zero = higher_zero && (disp_value_q[4*i +: 4] == 4'h0);
      if (higher_zero && !disp_dp_q[i]) begin
        blank_eff[i] = 1'b1;
      end
    end
  end
`else
  // Every digit that is not explicitly blanked is shown, leading zeros too.
  always_comb begin
    blank_eff = disp_blank_q;
  end
`endif

  // ---------------------------------------------------------------------------
  // Output decode for the current slot (registered by the state register)
  // ---------------------------------------------------------------------------
  always_comb begin
    an_d   = '1;
    segs_d = SEGS_OFF;
    dp_d   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i) && guard_done && !blank_eff[i]) begin
        an_d[i] = 1'b0;
        segs_d  = seg_decode(disp_value_q[4*i +: 4]);
        dp_d    = ~disp_dp_q[i];
      end
    end
  end

  assign an         = an_q;
  assign segs       = segs_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed, table-driven bench for seg7_scan_driver with
// NUM_DIGITS=4, CLK_DIV=4, GUARD=1 (16-cycle frames).
// Each table entry is loaded part-way through a frame. The remainder of that
// frame must still show the previous entry. Every slot of the following
// frame must show the new entry. Expected segment codes are hand-written.
// Honours SEG7_LEADING_ZERO_SUPPRESS_EN by selecting the suppressed lit mask.

module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int CD = 4;
  localparam int GD = 1;
  localparam int FRAME = ND * CD;

`ifdef SEG7_LEADING_ZERO_SUPPRESS_EN
  localparam bit LZS = 1'b1;
`else
  localparam bit LZS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [4*ND-1:0] value;
  logic [ND-1:0]  dp_in;
  logic [ND-1:0]  blank;
  logic           load;
  logic [6:0]     segs;
  logic           dp;
  logic [ND-1:0]  an;
  logic           frame_done;

  seg7_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .GUARD(GD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .blank      (blank),
    .load       (load),
    .segs       (segs),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp_in;     // also the expected dp request of each lit digit
    logic [3:0]  blank;
    int          load_at;   // sample index within the frame where load is driven
    bit          decoy;     // park a different load earlier in the same frame
    logic [27:0] exp_segs;  // {digit3, digit2, digit1, digit0}, 7 bits each
    logic [3:0]  lit;       // digits lit without suppression
    logic [3:0]  lit_lzs;   // digits lit with leading-zero suppression
  } vec_t;

  function automatic vec_t mk(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                              input int la, input bit dc, input logic [27:0] s,
                              input logic [3:0] l, input logic [3:0] lz);
    vec_t r;
    r.value = v; r.dp_in = d; r.blank = b; r.load_at = la; r.decoy = dc;
    r.exp_segs = s; r.lit = l; r.lit_lzs = lz;
    return r;
  endfunction

  // Wait (bounded) for a frame_done sample at a falling edge.
  task automatic wait_fd();
    int n = 0;
    @(negedge clk);
    while (!frame_done && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_seen", {31'd0, frame_done}, 32'd1);
  endtask

  // Called right after the falling edge where frame_done was seen. Checks all
  // 16 slot samples of the next frame against 'cur'. When do_load is set, it
  // also drives the load of 'nxt' at nxt.load_at.
  task automatic run_frame(input string tag, input vec_t cur, input vec_t nxt, input bit do_load);
    logic [3:0] litm;
    logic [3:0] exp_an;
    logic [6:0] exp_sg;
    logic       exp_dp;
    logic [27:0] sg;
    litm = LZS ? cur.lit_lzs : cur.lit;
    sg   = cur.exp_segs;
    for (int k = 1; k <= FRAME; k++) begin
      int c;
      int ix;
      @(negedge clk);
      c  = (k - 1) % CD;
      ix = (k - 1) / CD;
      exp_an = 4'hF;
      exp_sg = 7'h7F;
      exp_dp = 1'b1;
      if (litm[ix] && c >= GD) begin
        exp_an[ix] = 1'b0;
        exp_sg     = sg[ix*7 +: 7];
        exp_dp     = ~cur.dp_in[ix];
      end
      check($sformatf("%s slot%0d.%0d {an,segs,dp}", tag, ix, c),
            {20'd0, an, segs, dp}, {20'd0, exp_an, exp_sg, exp_dp});
      check($sformatf("%s k%0d frame_done", tag, k),
            {31'd0, frame_done}, {31'd0, (k == FRAME)});
      if (do_load && nxt.decoy && k == 2) begin
        value = 16'hEEEE; dp_in = 4'hF; blank = 4'h0; load = 1'b1;
      end
      if (do_load && nxt.decoy && k == 3) begin
        load = 1'b0; value = 16'h9999; dp_in = 4'h0; blank = 4'hF;
      end
      if (do_load && k == nxt.load_at) begin
        value = nxt.value; dp_in = nxt.dp_in; blank = nxt.blank; load = 1'b1;
      end
      if (do_load && k == nxt.load_at + 1) begin
        load = 1'b0; value = ~nxt.value; dp_in = ~nxt.dp_in; blank = ~nxt.blank;
      end
    end
  endtask

  vec_t vecs[8];
  vec_t init_v;
  vec_t prev;

  initial begin
    init_v  = mk(16'h0000, 4'b0000, 4'b0000, 0, 0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 4'b0001);
    vecs[0] = mk(16'h12AF, 4'b0000, 4'b0000, 5, 0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111, 4'b1111);
    vecs[1] = mk(16'h0008, 4'b0000, 4'b0000, 15, 1, {7'h40, 7'h40, 7'h40, 7'h00}, 4'b1111, 4'b0001);
    vecs[2] = mk(16'h3456, 4'b0001, 4'b0100, 5, 0, {7'h30, 7'h19, 7'h12, 7'h02}, 4'b1011, 4'b1011);
    vecs[3] = mk(16'h0050, 4'b0000, 4'b0000, 5, 1, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111, 4'b0011);
    vecs[4] = mk(16'h789B, 4'b1010, 4'b0000, 9, 0, {7'h78, 7'h00, 7'h10, 7'h03}, 4'b1111, 4'b1111);
    vecs[5] = mk(16'hCDE0, 4'b0001, 4'b0001, 5, 0, {7'h46, 7'h21, 7'h06, 7'h40}, 4'b1110, 4'b1110);
    vecs[6] = mk(16'h0000, 4'b0100, 4'b0000, 15, 0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 4'b0101);
    vecs[7] = mk(16'h4F71, 4'b0000, 4'b0000, 5, 0, {7'h19, 7'h0E, 7'h78, 7'h79}, 4'b1111, 4'b1111);

    // Reset state.
    rst_n = 1'b0; value = '0; dp_in = '0; blank = '0; load = 1'b0;
    repeat (3) @(negedge clk);
    check("reset an", {28'd0, an}, 32'hF);
    check("reset segs", {25'd0, segs}, 32'h7F);
    check("reset dp", {31'd0, dp}, 32'd1);
    check("reset frame_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;

    // First slot after release: guard cycle, then digit 0 shows '0'.
    @(negedge clk);
    check("post-reset cnt0 an", {28'd0, an}, 32'hF);
    @(negedge clk);
    check("post-reset cnt1 an", {28'd0, an}, 32'hE);
    check("post-reset cnt1 segs", {25'd0, segs}, 32'h40);
    check("post-reset cnt1 dp", {31'd0, dp}, 32'd1);

    wait_fd();

    // Table: check the frame of the previous entry while loading the next one.
    prev = init_v;
    for (int i = 0; i < 8; i++) begin
      run_frame($sformatf("v%0d-pre", i), prev, vecs[i], 1'b1);
      prev = vecs[i];
    end
    // No load: the last entry must persist for another frame.
    run_frame("v7-hold", prev, prev, 1'b0);

    // Mid-frame reset: a pending load is discarded and outputs go dark at once.
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 5) begin
        value = 16'h1111; dp_in = 4'h0; blank = 4'h0; load = 1'b1;
      end
      if (k == 6) load = 1'b0;
    end
    check("mid-slot pre-reset an lit", {28'd0, an}, 32'hD);
    rst_n = 1'b0;
    #1;
    check("mid-slot reset an", {28'd0, an}, 32'hF);
    check("mid-slot reset segs", {25'd0, segs}, 32'h7F);
    check("mid-slot reset dp", {31'd0, dp}, 32'd1);
    check("mid-slot reset frame_done", {31'd0, frame_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_fd();
    run_frame("after-reset", init_v, init_v, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
